lcd_ctrl: RTL and testbench

LCD_CTRL -- requirements
Module: lcd_ctrl

---
 rtl/lcd_ctrl_if.sv | 24 ++
 rtl/lcd_ctrl.sv | 176 +++++++++++++++++
 tb/tb_lcd_ctrl.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_ctrl_if.sv
// LSU-side register port of the character-LCD controller: store strobe,
// store data and status readback.
//
// Handshake: i_lcd_wren is a one-cycle strobe qualified by i_lcd_wdata and
// has no ready. A write is accepted at the rising edge where wren is high.
// o_lcd_status[1] (full) is advisory backpressure: a push made while the
// FIFO is full and not popping at that edge is dropped and sets sticky ovf.
interface lcd_ctrl_if;
    logic        i_lcd_wren;
    logic [31:0] i_lcd_wdata;
    logic [31:0] o_lcd_status;

    modport master (
        output i_lcd_wren,
        output i_lcd_wdata,
        input  o_lcd_status
    );

    modport slave (
        input  i_lcd_wren,
        input  i_lcd_wdata,
        output o_lcd_status
    );
endinterface

// File: rtl/lcd_ctrl.sv
// HD44780-style write-only LCD controller: a small command FIFO fed by LSU
// stores, drained by a timing FSM that drives RS/DATA/EN with setup, enable,
// hold and execution-wait phases.
module lcd_ctrl #(
    parameter int DEPTH       = 4,
    parameter int T_SETUP     = 2,
    parameter int T_EN        = 12,
    parameter int T_HOLD      = 2,
    parameter int T_EXEC      = 2000,
    parameter int T_EXEC_LONG = 82000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    lcd_ctrl_if.slave  lsu,
    output logic [7:0] o_lcd_data,
    output logic       o_lcd_rs,
    output logic       o_lcd_rw,
    output logic       o_lcd_en,
    output logic       o_lcd_on,
    output logic       o_lcd_blon,
    output logic [2:0] o_dbg_state
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(T_EXEC_LONG + 1);

    localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);
    localparam logic [CW-1:0] LD_SETUP  = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] LD_EN     = CW'(T_EN - 1);
    localparam logic [CW-1:0] LD_HOLD   = CW'(T_HOLD - 1);
    localparam logic [CW-1:0] LD_EXEC   = CW'(T_EXEC - 1);
    localparam logic [CW-1:0] LD_EXEC_L = CW'(T_EXEC_LONG - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_EN_HI = 3'd2,
        S_HOLD  = 3'd3,
        S_WAIT  = 3'd4
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_ld;

    logic [8:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          ovf;

    logic push_req, push_ok, pop, full, busy, is_long;
    logic unused_wdata;

    // Bits of the store word that carry no meaning for this block.
    assign unused_wdata = ^lsu.i_lcd_wdata[28:9];

    assign full     = (count == FULL_CNT);
    assign pop      = (state == S_IDLE) && (count != '0);
    assign push_req = lsu.i_lcd_wren && !lsu.i_lcd_wdata[29];
    // A simultaneous pop frees the slot, so a push into a full FIFO is kept.
    assign push_ok  = push_req && (!full || pop);
    // Clear display (0x01) and return home (0x02) need the long wait.
    assign is_long  = !o_lcd_rs && ((o_lcd_data == 8'h01) || (o_lcd_data == 8'h02));

    // FIFO storage; contents are only meaningful below count, so no reset.
    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= {lsu.i_lcd_wdata[8], lsu.i_lcd_wdata[7:0]};
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
            if (push_req && !push_ok) ovf <= 1'b1;
        end
    end

    // Panel bus latch (loaded on pop, held through WAIT) and power controls.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_lcd_rs   <= 1'b0;
            o_lcd_data <= 8'h00;
            o_lcd_on   <= 1'b0;
            o_lcd_blon <= 1'b0;
        end else begin
            if (pop) begin
                o_lcd_rs   <= mem[rd_ptr][8];
                o_lcd_data <= mem[rd_ptr][7:0];
            end
            if (lsu.i_lcd_wren) begin
                o_lcd_on   <= lsu.i_lcd_wdata[31];
                o_lcd_blon <= lsu.i_lcd_wdata[30];
            end
        end
    end

    // State register and phase counter: load on entry, count down to zero.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state) begin
                cnt <= cnt_ld;
            end else if (cnt != '0) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

    // Next-state selection and the counter value for the state being entered.
    always_comb begin
        state_nxt = state;
        cnt_ld    = '0;
        case (state)
            S_IDLE: begin
                if (count != '0) begin
                    state_nxt = S_SETUP;
                    cnt_ld    = LD_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt == '0) begin
                    state_nxt = S_EN_HI;
                    cnt_ld    = LD_EN;
                end
            end
            S_EN_HI: begin
                if (cnt == '0) begin
                    state_nxt = S_HOLD;
                    cnt_ld    = LD_HOLD;
                end
            end
            S_HOLD: begin
                if (cnt == '0) begin
                    state_nxt = S_WAIT;
                    cnt_ld    = is_long ? LD_EXEC_L : LD_EXEC;
                end
            end
            S_WAIT: begin
                if (cnt == '0) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Moore outputs: enable strobe, fixed write mode, status word, debug state.
    always_comb begin
        o_lcd_en         = (state == S_EN_HI);
        o_lcd_rw         = 1'b0;
        o_dbg_state      = state;
        busy             = (state != S_IDLE) || (count != '0);
        lsu.o_lcd_status = '0;
        lsu.o_lcd_status[0]         = busy;
        lsu.o_lcd_status[1]         = full;
        lsu.o_lcd_status[2]         = ovf;
        lsu.o_lcd_status[3 +: AW+1] = count;
    end

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed bench for lcd_ctrl with short timing parameters.
module tb_lcd_ctrl;
    logic       clk;
    logic       rst_n;
    logic [7:0] lcd_data;
    logic       lcd_rs, lcd_rw, lcd_en, lcd_on, lcd_blon;
    logic [2:0] dbg_state;

    lcd_ctrl_if lsu();

    lcd_ctrl #(
        .DEPTH(4), .T_SETUP(1), .T_EN(2), .T_HOLD(1),
        .T_EXEC(4), .T_EXEC_LONG(8)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst_n),
        .lsu         (lsu),
        .o_lcd_data  (lcd_data),
        .o_lcd_rs    (lcd_rs),
        .o_lcd_rw    (lcd_rw),
        .o_lcd_en    (lcd_en),
        .o_lcd_on    (lcd_on),
        .o_lcd_blon  (lcd_blon),
        .o_dbg_state (dbg_state)
    );

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_EN_HI = 3'd2;

    typedef struct {
        logic [31:0] wdata;
        logic        exp_on;
        logic        exp_blon;
        logic        exp_rs;
        logic [7:0]  exp_data;
        int          exp_busy;
        int          exp_en;
    } vec_t;

    vec_t       vecs [7];
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [8:0] exp_q [$];
    logic       mon_on  = 1'b0;
    logic       prev_en = 1'b0;
    logic [8:0] mon_e;

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every EN rising edge must carry the next expected entry.
    always @(posedge clk) begin
        #1;
        if (mon_on && lcd_en && !prev_en) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL drain_extra: got %h required none", {lcd_rs, lcd_data});
            end else begin
                mon_e = exp_q.pop_front();
                check("drain_order", 32'({lcd_rs, lcd_data}), 32'(mon_e));
            end
        end
        prev_en = lcd_en;
    end

    task automatic write(input logic [31:0] d);
        lsu.i_lcd_wren  = 1'b1;
        lsu.i_lcd_wdata = d;
        tick();
        lsu.i_lcd_wren  = 1'b0;
        lsu.i_lcd_wdata = 32'h0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_not_busy(input string name);
        int cyc = 0;
        while (lsu.o_lcd_status[0] && cyc < 500) begin
            tick();
            cyc++;
        end
        check(name, 32'(lsu.o_lcd_status[0]), 32'd0);
    endtask

    // One write from idle: measure busy length, EN width and latched bus.
    task automatic run_vec(input vec_t v, input string tag);
        int   busy_n = 0;
        int   en_n   = 0;
        logic got    = 1'b0;
        logic cap_rs = 1'b0;
        logic [7:0] cap_d = 8'h00;
        write(v.wdata);
        check({tag, "_on"},   32'(lcd_on),   32'(v.exp_on));
        check({tag, "_blon"}, 32'(lcd_blon), 32'(v.exp_blon));
        while (lsu.o_lcd_status[0] && busy_n < 100) begin
            if (lcd_en) begin
                en_n++;
                if (!got) begin
                    got    = 1'b1;
                    cap_rs = lcd_rs;
                    cap_d  = lcd_data;
                end
            end
            check({tag, "_rw"}, 32'(lcd_rw), 32'd0);
            tick();
            busy_n++;
        end
        check({tag, "_busy_cycles"}, busy_n, v.exp_busy);
        check({tag, "_en_cycles"},   en_n,   v.exp_en);
        if (v.exp_en != 0) begin
            check({tag, "_rs"},   32'(cap_rs), 32'(v.exp_rs));
            check({tag, "_data"}, 32'(cap_d),  32'(v.exp_data));
        end
        check({tag, "_status_end"}, lsu.o_lcd_status, 32'h0);
    endtask

    initial begin
        vecs[0] = '{32'h8000_0141, 1'b1, 1'b0, 1'b1, 8'h41, 9,  2};
        vecs[1] = '{32'h0000_0001, 1'b0, 1'b0, 1'b0, 8'h01, 13, 2};
        vecs[2] = '{32'h4000_0002, 1'b0, 1'b1, 1'b0, 8'h02, 13, 2};
        vecs[3] = '{32'hC000_0103, 1'b1, 1'b1, 1'b1, 8'h03, 9,  2};
        vecs[4] = '{32'h6000_0000, 1'b0, 1'b1, 1'b0, 8'h00, 0,  0};
        vecs[5] = '{32'h8000_00FF, 1'b1, 1'b0, 1'b0, 8'hFF, 9,  2};
        vecs[6] = '{32'h0000_0101, 1'b0, 1'b0, 1'b1, 8'h01, 9,  2};

        lsu.i_lcd_wren  = 1'b0;
        lsu.i_lcd_wdata = 32'h0;
        rst_n = 1'b0;
        #1;
        check("rst_status", lsu.o_lcd_status, 32'h0);
        check("rst_en",     32'(lcd_en),   32'd0);
        check("rst_rs",     32'(lcd_rs),   32'd0);
        check("rst_rw",     32'(lcd_rw),   32'd0);
        check("rst_data",   32'(lcd_data), 32'd0);
        check("rst_on",     32'(lcd_on),   32'd0);
        check("rst_blon",   32'(lcd_blon), 32'd0);
        check("rst_state",  32'(dbg_state), 32'(ST_IDLE));
        tick();
        tick();
        rst_n = 1'b1;

        // Table of single writes
        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Six back-to-back writes while busy: one popped, four queued, one dropped
        exp_q.delete();
        for (int i = 0; i < 5; i++) exp_q.push_back(9'h110 + 9'(i));
        mon_on = 1'b1;
        for (int i = 0; i < 6; i++) write(32'h8000_0110 + 32'(i));
        check("ovf_status", lsu.o_lcd_status, 32'h0000_0027);
        wait_not_busy("ovf_drain_timeout");
        check("ovf_leftover", exp_q.size(), 0);
        check("ovf_sticky", lsu.o_lcd_status, 32'h0000_0004);
        mon_on = 1'b0;
        do_reset();
        check("ovf_cleared", lsu.o_lcd_status, 32'h0);

        // Push at the pop edge with the FIFO full
        exp_q.delete();
        for (int i = 0; i < 6; i++) exp_q.push_back(9'h120 + 9'(i));
        mon_on = 1'b1;
        for (int i = 0; i < 5; i++) write(32'h8000_0120 + 32'(i));
        check("full_status", lsu.o_lcd_status, 32'h0000_0023);
        begin
            int cyc = 0;
            while (dbg_state != ST_IDLE && cyc < 50) begin
                tick();
                cyc++;
            end
            check("full_reach_idle", 32'(dbg_state), 32'(ST_IDLE));
        end
        write(32'h8000_0125);
        check("full_pushpop", lsu.o_lcd_status, 32'h0000_0023);
        wait_not_busy("full_drain_timeout");
        check("full_leftover", exp_q.size(), 0);
        check("full_end_status", lsu.o_lcd_status, 32'h0);
        mon_on = 1'b0;

        // Reset asserted during EN_HI
        write(32'h8000_0141);
        write(32'h8000_0142);
        begin
            int cyc = 0;
            while (dbg_state != ST_EN_HI && cyc < 20) begin
                tick();
                cyc++;
            end
            check("rst_mid_reach_en", 32'(dbg_state), 32'(ST_EN_HI));
        end
        check("rst_mid_en_before", 32'(lcd_en), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_en",     32'(lcd_en),   32'd0);
        check("rst_mid_status", lsu.o_lcd_status, 32'h0);
        check("rst_mid_data",   32'(lcd_data), 32'd0);
        check("rst_mid_on",     32'(lcd_on),   32'd0);
        tick();
        rst_n = 1'b1;
        run_vec(vecs[0], "post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
